uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumes the byte stream from the UART receiver: `recv_en` strobe plus `recv_data` byte.
- Assembles framed command packets: header, command, length, payload, checksum.
- Presents each verified command to the game/control logic through a valid/ready handshake.
- Malformed frames are discarded and flagged with a one-cycle error pulse.

Parameters:
- CLK_FRE, 50, system clock in MHz.
- UART_RATE, 115200, line baud rate; used only for the timeout length.
- HEADER, 8'hA5, frame start byte.
- MAX_LEN, 8, maximum payload bytes per frame (1..15).
- TIMEOUT_BYTES, 4, inter-byte silence, in 10-bit character times, that aborts a frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- recv_en  in  1  byte-available level from the UART receiver. May stay high for several consecutive cycles per byte.
- recv_data  in  8  received byte; stable whenever recv_en is high.
- cmd_valid  out  1  verified command available.
- cmd_ready  in  1  consumer accepts the command.
- cmd_code  out  8  command byte.
- cmd_len  out  8  payload length in bytes.
- cmd_payload  out  MAX_LEN*8  payload; byte i at [8i+7:8i]; bytes at index >= cmd_len read 0.
- frame_err  out  1  one-cycle pulse per discarded frame or dropped byte.

Behaviour:
- Clocking/reset: single clock domain; every register cleared asynchronously when rst_n is low.
- Reset values: all outputs 0; state HUNT; checksum 0.
- Byte strobe: byte_stb = recv_en & ~recv_en_d, with recv_en_d registered. Exactly one byte is taken per rising edge of recv_en; recv_data is sampled in the byte_stb cycle.
- Checksum: 8-bit sum, mod 256, of cmd, len and all payload bytes. The header is excluded.
- States (all transitions on byte_stb unless noted):
  - HUNT:
    - byte == HEADER -> CMD; clear checksum, payload and index.
    - any other byte is ignored silently, no frame_err.
  - CMD: store cmd_code, checksum = byte -> LEN.
  - LEN: store cmd_len, add to checksum.
    - len > MAX_LEN -> frame_err, HUNT.
    - len == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: write payload[index], add to checksum, index++. When index reaches len-1 -> CSUM.
  - CSUM: compare byte with checksum.
    - equal -> HOLD; cmd_valid rises the next cycle (one cycle after the checksum byte_stb).
    - mismatch -> frame_err, HUNT.
  - HOLD:
    - cmd_valid = 1; cmd_code, cmd_len and cmd_payload held stable.
    - cmd_valid & cmd_ready -> cmd_valid low next cycle, state HUNT.
    - any byte_stb in HOLD is dropped and pulses frame_err, including a byte equal to HEADER.
- Same-cycle handshake and byte: if the handshake and byte_stb occur in the same cycle in HOLD, the byte is dropped (frame_err) and the state still returns to HUNT.
- cmd_ready may be high while cmd_valid is low; this has no effect.
- Reset mid-frame: the partial frame is lost; the block resumes in HUNT.
- frame_err is never high for more than one consecutive cycle per cause. Simultaneous causes (timeout and drop) produce a single pulse.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined:
  - Adds an inter-byte counter, width sized for TIMEOUT_CYC = CLK_FRE*1000000/UART_RATE*10*TIMEOUT_BYTES.
  - The counter clears on every byte_stb and in HUNT/HOLD, and counts in CMD, LEN, DATA and CSUM.
  - On reaching TIMEOUT_CYC-1: pulse frame_err, go to HUNT.
- Not defined: no counter; a partial frame waits indefinitely for further bytes.

Test Plan:
- Valid frame: bytes A5 01 02 10 20 33 -> cmd_valid one cycle after the 0x33 strobe, cmd_code=01, cmd_len=02, cmd_payload[15:0]=16'h2010, upper bytes 0. cmd_ready=1 -> cmd_valid low next cycle.
- Bad checksum: A5 01 02 10 20 34 -> single frame_err pulse, no cmd_valid. A following valid A5 07 00 07 -> cmd_code=07, cmd_len=0.
- Length limit: A5 03 09 ... with MAX_LEN=8 -> frame_err on the 0x09 strobe, state HUNT. Trailing bytes that are not 0xA5 are ignored.
- Back-pressure: valid frame, cmd_ready held 0; send A5 02 00 02 -> four frame_err pulses, first command outputs unchanged. Raise cmd_ready -> accepted, no second cmd_valid.
- Multi-cycle strobe: each byte's recv_en held high 5 cycles, frame A5 01 01 FF 01 (checksum 01+01+FF = 0x01) -> one cmd_valid, payload byte0=FF. Mid-frame rst_n low for 1 cycle -> outputs 0, next frame parsed cleanly.
- Timeout (UART_CMD_TIMEOUT_EN, CLK_FRE=50, TIMEOUT_BYTES=4): send A5 01, then idle 17360 cycles -> frame_err near cycle 17359 after the last strobe. Next valid frame accepted. Without the macro, no frame_err.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames A5/cmd/len/payload/csum byte stream into verified commands; optional inter-byte timeout via UART_CMD_TIMEOUT_EN
module uart_cmd_parser #(
  parameter int          CLK_FRE       = 50,
  parameter int          UART_RATE     = 115200,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int          MAX_LEN       = 8,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 recv_en,
  input  logic [7:0]           recv_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [7:0]           cmd_len,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  output logic                 frame_err
);
  typedef enum logic [2:0] {HUNT, CMD, LEN, DATA, CSUM, HOLD} state_t;
  state_t               state_q, state_d;
  logic                 recv_en_q;
  logic [7:0]           csum_q, csum_d, code_q, code_d, len_q, len_d;
  logic [3:0]           idx_q, idx_d;
  logic [MAX_LEN*8-1:0] payload_q, payload_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic                 byte_stb;
  assign byte_stb = recv_en & ~recv_en_q;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TIMEOUT_CYC = CLK_FRE * 1000000 / UART_RATE * 10 * TIMEOUT_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          idle, timeout;
  assign idle    = (state_q == HUNT) || (state_q == HOLD);
  assign timeout = !byte_stb && !idle && (cnt_q == TW'(TIMEOUT_CYC - 1));
  // Inter-byte silence counter, only runs while a frame is partially assembled
  always_comb cnt_d = (byte_stb || idle || timeout) ? '0 : cnt_q + 1'b1;
  // Counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`endif
  // Frame assembly next-state logic
  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    code_d    = code_q;
    len_d     = len_q;
    idx_d     = idx_q;
    payload_d = payload_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    case (state_q)
      HUNT: if (byte_stb && recv_data == HEADER) begin
        state_d   = CMD;
        csum_d    = '0;
        payload_d = '0;
        idx_d     = '0;
      end
      CMD: if (byte_stb) begin
        code_d  = recv_data;
        csum_d  = recv_data;
        state_d = LEN;
      end
      LEN: if (byte_stb) begin
        len_d   = recv_data;
        csum_d  = csum_q + recv_data;
        err_d   = recv_data > 8'(MAX_LEN);
        state_d = err_d ? HUNT : (recv_data == 8'd0 ? CSUM : DATA);
      end
      DATA: if (byte_stb) begin
        payload_d[{idx_q, 3'b000} +: 8] = recv_data;
        csum_d  = csum_q + recv_data;
        idx_d   = idx_q + 4'd1;
        state_d = ({4'b0, idx_q} == len_q - 8'd1) ? CSUM : DATA;
      end
      CSUM: if (byte_stb) begin
        valid_d = recv_data == csum_q;
        err_d   = !valid_d;
        state_d = valid_d ? HOLD : HUNT;
      end
      HOLD: begin
        err_d = byte_stb;
        if (cmd_ready) begin
          valid_d = 1'b0;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
`ifdef UART_CMD_TIMEOUT_EN
    if (timeout) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
`endif
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= HUNT;
      recv_en_q <= 1'b0;
      csum_q    <= '0;
      code_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      recv_en_q <= recv_en;
      csum_q    <= csum_d;
      code_q    <= code_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      payload_q <= payload_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  assign cmd_valid   = valid_q;
  assign cmd_code    = code_q;
  assign cmd_len     = len_q;
  assign cmd_payload = payload_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scoreboard bench for uart_cmd_parser with directed frames
module tb_uart_cmd_parser;
  localparam int ML = 8;
  typedef struct {
    logic           is_err;
    logic [7:0]     code;
    logic [7:0]     len;
    logic [ML*8-1:0] pl;
  } exp_t;
  logic clk = 0, rst_n = 0, recv_en = 0, cmd_ready = 0;
  logic [7:0] recv_data = 0;
  logic cmd_valid, frame_err;
  logic [7:0] cmd_code, cmd_len;
  logic [ML*8-1:0] cmd_payload;
  int errors = 0, checks = 0;
  exp_t q[$];
  uart_cmd_parser dut (
    .clk(clk), .rst_n(rst_n), .recv_en(recv_en), .recv_data(recv_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic push_cmd(input logic [7:0] c, input logic [7:0] l, input logic [ML*8-1:0] p);
    exp_t e;
    e.is_err = 0; e.code = c; e.len = l; e.pl = p;
    q.push_back(e);
  endtask
  task automatic push_err();
    exp_t e;
    e.is_err = 1; e.code = 0; e.len = 0; e.pl = 0;
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    recv_data = b;
    recv_en = 1;
    repeat (hold) @(negedge clk);
    recv_en = 0;
  endtask
  task automatic send_frame(input logic [7:0] bytes[], input int hold);
    foreach (bytes[i]) send(bytes[i], hold);
  endtask
  logic prev_valid = 0;
  logic [7:0] h_code, h_len;
  logic [ML*8-1:0] h_pl;
  // Monitor: pop the expected entry on every cmd_valid rise or frame_err pulse
  always @(negedge clk) begin
    if (!rst_n) prev_valid <= 0;
    else begin
      if (frame_err) begin
        if (q.size() == 0 || !q[0].is_err) check("unexpected_frame_err", 1, 0);
        else begin
          check("frame_err", frame_err, 1);
          void'(q.pop_front());
        end
      end
      if (cmd_valid && !prev_valid) begin
        if (q.size() == 0 || q[0].is_err) check("unexpected_cmd_valid", 1, 0);
        else begin
          check("cmd_code", cmd_code, q[0].code);
          check("cmd_len", cmd_len, q[0].len);
          check("cmd_payload", cmd_payload, q[0].pl);
          void'(q.pop_front());
        end
        h_code = cmd_code; h_len = cmd_len; h_pl = cmd_payload;
      end else if (cmd_valid) begin
        check("hold_code", cmd_code, h_code);
        check("hold_len", cmd_len, h_len);
        check("hold_payload", cmd_payload, h_pl);
      end
      prev_valid <= cmd_valid;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", cmd_code, 0);
    check("rst_len", cmd_len, 0);
    check("rst_payload", cmd_payload, 0);
    rst_n = 1;
    // valid frame with latency and handshake
    push_cmd(8'h01, 8'h02, 64'h2010);
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20}, 1);
    send(8'h33, 1);
    check("valid_latency", cmd_valid, 1);
    repeat (3) @(negedge clk);
    check("valid_held", cmd_valid, 1);
    cmd_ready = 1;
    @(negedge clk);
    check("valid_drop", cmd_valid, 0);
    cmd_ready = 0;
    // bad checksum then zero-length frame
    push_err();
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}, 1);
    repeat (3) @(negedge clk);
    check("badsum_no_valid", cmd_valid, 0);
    push_cmd(8'h07, 8'h00, 64'h0);
    send_frame('{8'hA5, 8'h07, 8'h00, 8'h07}, 1);
    cmd_ready = 1;
    repeat (2) @(negedge clk);
    // length over limit, trailing bytes ignored
    push_err();
    send_frame('{8'hA5, 8'h03, 8'h09, 8'h11, 8'h22}, 1);
    repeat (3) @(negedge clk);
    check("len_no_valid", cmd_valid, 0);
    // back-pressure: every byte in HOLD is dropped with an error
    cmd_ready = 0;
    push_cmd(8'h05, 8'h01, 64'h44);
    send_frame('{8'hA5, 8'h05, 8'h01, 8'h44, 8'h4A}, 1);
    repeat (4) push_err();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h02}, 1);
    repeat (3) @(negedge clk);
    check("bp_still_valid", cmd_valid, 1);
    check("bp_code", cmd_code, 8'h05);
    cmd_ready = 1;
    repeat (5) @(negedge clk);
    check("bp_accepted", cmd_valid, 0);
    // same-cycle handshake and byte: byte dropped, back to HUNT
    cmd_ready = 0;
    push_cmd(8'h06, 8'h00, 64'h0);
    send_frame('{8'hA5, 8'h06, 8'h00, 8'h06}, 1);
    repeat (2) @(negedge clk);
    push_err();
    recv_data = 8'hA5; recv_en = 1; cmd_ready = 1;
    @(negedge clk);
    recv_en = 0; cmd_ready = 0;
    repeat (2) @(negedge clk);
    check("same_cycle_valid", cmd_valid, 0);
    cmd_ready = 1;
    // multi-cycle strobe
    push_cmd(8'h01, 8'h01, 64'hFF);
    send_frame('{8'hA5, 8'h01, 8'h01, 8'hFF, 8'h01}, 5);
    repeat (3) @(negedge clk);
    // mid-frame reset
    send_frame('{8'hA5, 8'h01}, 1);
    rst_n = 0;
    @(negedge clk);
    check("midrst_valid", cmd_valid, 0);
    check("midrst_code", cmd_code, 0);
    check("midrst_len", cmd_len, 0);
    check("midrst_payload", cmd_payload, 0);
    rst_n = 1;
    push_cmd(8'h09, 8'h01, 64'hAA);
    send_frame('{8'hA5, 8'h09, 8'h01, 8'hAA, 8'hB4}, 1);
    repeat (3) @(negedge clk);
    // partial frame then silence
    send_frame('{8'hA5, 8'h01}, 1);
`ifdef UART_CMD_TIMEOUT_EN
    push_err();
    repeat (17300) @(negedge clk);
    check("timeout_not_early", q.size(), 1);
    repeat (200) @(negedge clk);
    check("timeout_fired", q.size(), 0);
`else
    repeat (500) @(negedge clk);
    check("no_timeout", q.size(), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
`endif
    push_cmd(8'h02, 8'h02, 64'h5678);
    send_frame('{8'hA5, 8'h02, 8'h02, 8'h78, 8'h56, 8'hD2}, 1);
    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
